// File: rtl/rv32i_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// rv32i_fetch : instruction fetch stage -- PC, req/ack memory reads, {instr,pc}
//               output buffer to decode, redirect flush.
// Option     : RV32I_FETCH_SKID_EN selects a 2-entry buffer (else 1 entry).
// Revision   : 1.0
// ============================================================================
module rv32i_fetch #(
  parameter int              XLEN         = 32,
  parameter int              ILEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [ILEN-1:0] mem_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            decode_ready_i,
  output logic [ILEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_data_o,
  output logic            data_ready_o,
  output logic            clear_o
);

`ifdef RV32I_FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_REQUEST  = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DISCARD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [ILEN-1:0] instr_q [DEPTH];
  logic [ILEN-1:0] instr_d [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];

  logic            pop;
  logic            push;
  logic [CW-1:0]   cnt_after_pop;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign data_ready_o  = (count_q != '0);
  assign instruction_o = instr_q[0];
  assign pc_data_o     = pc_q[0];
  assign clear_o       = redirect_i;

  assign pop           = data_ready_o && decode_ready_i;
  assign cnt_after_pop = count_q - CW'(pop);

  // Credit only gates a fresh request; an issued request is held until acked.
  assign mem_req_o  = (state_q != ST_REQUEST) || (cnt_after_pop < CW'(DEPTH));
  assign mem_addr_o = (state_q == ST_REQUEST) ? fetch_pc_q : req_addr_q;
  assign push       = mem_req_o && mem_ack_i && (state_q != ST_DISCARD) && !redirect_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = mem_addr_o;
    count_d    = count_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    if (redirect_i) begin
      count_d    = '0;
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      state_d    = (mem_req_o && !mem_ack_i) ? ST_DISCARD : ST_REQUEST;
    end else begin
`ifdef RV32I_FETCH_SKID_EN
      if (pop) begin
        instr_d[0] = instr_q[1];
        pc_d[0]    = pc_q[1];
      end
`endif
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (cnt_after_pop == CW'(i))) begin
          instr_d[i] = mem_data_i;
          pc_d[i]    = mem_addr_o;
        end
      end
      if (push) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      count_d = cnt_after_pop + CW'(push);

      case (state_q)
        ST_REQUEST:  if (mem_req_o && !mem_ack_i) state_d = ST_WAIT_ACK;
        ST_WAIT_ACK: if (mem_ack_i) state_d = ST_REQUEST;
        ST_DISCARD:  if (mem_ack_i) state_d = ST_REQUEST;
        default:     state_d = ST_REQUEST;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_REQUEST;
      fetch_pc_q <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_rv32i_fetch : randomized bench for rv32i_fetch against a scoreboard model
// Revision       : 1.0
// ============================================================================
module tb_rv32i_fetch;

`ifdef RV32I_FETCH_SKID_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam logic [31:0] K = 32'h5A5A_0013;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        decode_ready_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_data_o;
  logic        data_ready_o;
  logic        clear_o;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = 0;
  bit mem_const = 1'b1;
  int wait_cnt = 0;

  always #5 clk_i = ~clk_i;

  rv32i_fetch dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .decode_ready_i(decode_ready_i),
    .instruction_o(instruction_o), .pc_data_o(pc_data_o),
    .data_ready_o(data_ready_o), .clear_o(clear_o)
  );

  // Memory: acks after mem_lat cycles of a held request; data is a function of address
  assign mem_ack_i  = mem_req_o && (wait_cnt >= mem_lat);
  assign mem_data_i = mem_const ? 32'h0000_0013 : (mem_addr_o ^ K);
  always @(posedge clk_i) wait_cnt <= (!mem_req_o || mem_ack_i) ? 0 : wait_cnt + 1;

  // Scoreboard model: buffered {instr,pc} entries, next fetch address, outstanding request
  int          m_cnt;
  logic [31:0] m_ins [2];
  logic [31:0] m_pc  [2];
  logic [31:0] m_fetch, m_out_addr;
  bit          m_out, m_stale;
  logic        e_valid, e_pop, e_req, e_push;
  int          e_cap;
  logic [31:0] e_addr, e_data;

  always_comb begin
    e_valid = (m_cnt > 0);
    e_pop   = e_valid && decode_ready_i;
    e_cap   = m_cnt - (e_pop ? 1 : 0);
    e_req   = m_out || (e_cap < D);
    e_addr  = m_out ? m_out_addr : m_fetch;
    e_push  = e_req && mem_ack_i && !m_stale && !redirect_i;
    e_data  = mem_const ? 32'h0000_0013 : (e_addr ^ K);
  end

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_cnt <= 0; m_fetch <= 32'h0; m_out <= 1'b0; m_stale <= 1'b0; m_out_addr <= 32'h0;
    end else if (redirect_i) begin
      m_cnt      <= 0;
      m_fetch    <= {redirect_pc_i[31:2], 2'b00};
      m_out      <= e_req && !mem_ack_i;
      m_stale    <= e_req && !mem_ack_i;
      m_out_addr <= e_addr;
    end else begin
      if (e_pop) begin
        m_ins[0] <= m_ins[1];
        m_pc[0]  <= m_pc[1];
      end
      if (e_push) begin
        m_ins[e_cap] <= e_data;
        m_pc[e_cap]  <= e_addr;
        m_fetch      <= e_addr + 32'd4;
      end
      m_cnt <= e_cap + (e_push ? 1 : 0);
      if (e_req) begin
        m_out      <= !mem_ack_i;
        m_stale    <= m_stale && !mem_ack_i;
        m_out_addr <= e_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; decode_ready_i = 1'b1;
    mem_lat = 0; mem_const = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (data_ready_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", data_ready_o); else n_pass++;
    n_checks++; if (instruction_o !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instruction_o); else n_pass++;
    n_checks++; if (pc_data_o !== 32'h0) $display("FAIL rst_pc got=%h exp=0", pc_data_o); else n_pass++;
    redirect_i = 1'b1; #1;
    n_checks++; if (clear_o !== 1'b1) $display("FAIL rst_clear_hi got=%b exp=1", clear_o); else n_pass++;
    redirect_i = 1'b0; #1;
    n_checks++; if (clear_o !== 1'b0) $display("FAIL rst_clear_lo got=%b exp=0", clear_o); else n_pass++;
    tick();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (mem_req_o !== 1'b1) $display("FAIL rst_first_req got=%b exp=1", mem_req_o); else n_pass++;
    n_checks++; if (mem_addr_o !== 32'h0) $display("FAIL rst_first_addr got=%h exp=0", mem_addr_o); else n_pass++;
    n_checks++; if (data_ready_o !== 1'b0) $display("FAIL rst_first_valid got=%b exp=0", data_ready_o); else n_pass++;
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk_i);
      n_checks++; if (data_ready_o !== 1'b1) $display("FAIL zw_valid k=%0d got=%b exp=1", k, data_ready_o); else n_pass++;
      n_checks++; if (pc_data_o !== 32'(4 * k)) $display("FAIL zw_pc k=%0d got=%h exp=%h", k, pc_data_o, 32'(4 * k)); else n_pass++;
      n_checks++; if (instruction_o !== 32'h13) $display("FAIL zw_instr k=%0d got=%h exp=13", k, instruction_o); else n_pass++;
      n_checks++; if (mem_req_o !== e_req) $display("FAIL zw_req k=%0d got=%b exp=%b", k, mem_req_o, e_req); else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    int last_pop = -1;
    int npops = 0;
    tick();
    mem_const = 1'b0; mem_lat = 3;
    redirect_i = 1'b1; redirect_pc_i = ($urandom & 32'h0000_FFFC) | 32'h0001_0000;
    tick();
    redirect_i = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      n_checks++; if (data_ready_o !== e_valid) $display("FAIL ws_valid c=%0d got=%b exp=%b", c, data_ready_o, e_valid); else n_pass++;
      if (e_valid) begin
        n_checks++;
        if ({instruction_o, pc_data_o} !== {m_ins[0], m_pc[0]})
          $display("FAIL ws_head c=%0d got=%h/%h exp=%h/%h", c, instruction_o, pc_data_o, m_ins[0], m_pc[0]);
        else n_pass++;
      end
      n_checks++; if (mem_req_o !== e_req) $display("FAIL ws_req c=%0d got=%b exp=%b", c, mem_req_o, e_req); else n_pass++;
      if (e_req) begin
        n_checks++; if (mem_addr_o !== e_addr) $display("FAIL ws_addr c=%0d got=%h exp=%h", c, mem_addr_o, e_addr); else n_pass++;
      end
      if (e_pop) begin
        if (last_pop >= 0) begin
          n_checks++; if (c - last_pop != 4) $display("FAIL ws_gap c=%0d got=%0d exp=4", c, c - last_pop); else n_pass++;
        end
        last_pop = c;
        npops++;
      end
      tick();
    end
    n_checks++; if (npops < 10) $display("FAIL ws_count got=%0d exp>=10", npops); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] f_pc, f_ins;
    mem_lat = 0; mem_const = 1'b0; decode_ready_i = 1'b1;
    repeat (4) tick();
    decode_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (i == 0) begin f_pc = m_pc[0]; f_ins = m_ins[0]; end
      n_checks++; if (data_ready_o !== 1'b1) $display("FAIL st_valid i=%0d got=%b exp=1", i, data_ready_o); else n_pass++;
      n_checks++;
      if ({instruction_o, pc_data_o} !== {f_ins, f_pc})
        $display("FAIL st_frozen i=%0d got=%h/%h exp=%h/%h", i, instruction_o, pc_data_o, f_ins, f_pc);
      else n_pass++;
      n_checks++; if (mem_req_o !== e_req) $display("FAIL st_req i=%0d got=%b exp=%b", i, mem_req_o, e_req); else n_pass++;
      if (i == 4) begin
        n_checks++; if (mem_req_o !== 1'b0) $display("FAIL st_req_full got=%b exp=0", mem_req_o); else n_pass++;
      end
      tick();
    end
    decode_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      n_checks++; if (data_ready_o !== e_valid) $display("FAIL st_rel_valid i=%0d got=%b exp=%b", i, data_ready_o, e_valid); else n_pass++;
      if (e_valid) begin
        n_checks++; if (pc_data_o !== m_pc[0]) $display("FAIL st_rel_pc i=%0d got=%h exp=%h", i, pc_data_o, m_pc[0]); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_redirect_pending();
    int n = 0;
    bit found = 1'b0;
    mem_const = 1'b0; mem_lat = 3; decode_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
    tick();
    redirect_i = 1'b0;
    while (!found && n < 30) begin
      @(negedge clk_i);
      if (mem_req_o && mem_addr_o == 32'h40 && !m_stale && wait_cnt == 0) found = 1'b1;
      else begin tick(); n++; end
    end
    n_checks++; if (!found) $display("FAIL rp_setup got=timeout exp=request_to_40"); else n_pass++;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    @(negedge clk_i);
    n_checks++; if (clear_o !== 1'b1) $display("FAIL rp_clear got=%b exp=1", clear_o); else n_pass++;
    n_checks++; if ({mem_req_o, mem_ack_i} !== 2'b10) $display("FAIL rp_pending got=%b exp=10", {mem_req_o, mem_ack_i}); else n_pass++;
    tick();
    redirect_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (data_ready_o !== 1'b0) $display("FAIL rp_flushed got=%b exp=0", data_ready_o); else n_pass++;
    n = 0;
    while (!data_ready_o && n < 20) begin tick(); @(negedge clk_i); n++; end
    n_checks++; if (pc_data_o !== 32'h100) $display("FAIL rp_next_pc got=%h exp=00000100", pc_data_o); else n_pass++;
    n_checks++; if (instruction_o !== (32'h100 ^ K)) $display("FAIL rp_next_instr got=%h exp=%h", instruction_o, 32'h100 ^ K); else n_pass++;
    tick();
  endtask

  task automatic test_redirect_ack_pop(input logic [31:0] raw, input string tag);
    logic [31:0] t;
    t = {raw[31:2], 2'b00};
    mem_const = 1'b0; mem_lat = 0; decode_ready_i = 1'b1;
    repeat (4) tick();
    redirect_i = 1'b1; redirect_pc_i = raw;
    @(negedge clk_i);
    n_checks++; if ({data_ready_o, mem_ack_i, clear_o} !== 3'b111) $display("FAIL %s_pre got=%b exp=111", tag, {data_ready_o, mem_ack_i, clear_o}); else n_pass++;
    tick();
    redirect_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (data_ready_o !== 1'b0) $display("FAIL %s_gap got=%b exp=0", tag, data_ready_o); else n_pass++;
    n_checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, t}) $display("FAIL %s_fetch got=%b/%h exp=1/%h", tag, mem_req_o, mem_addr_o, t); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk_i);
      n_checks++;
      if ({data_ready_o, pc_data_o, instruction_o} !== {1'b1, t + 32'(4 * k), (t + 32'(4 * k)) ^ K})
        $display("FAIL %s_seq k=%0d got=%b/%h/%h exp=1/%h/%h", tag, k, data_ready_o, pc_data_o, instruction_o, t + 32'(4 * k), (t + 32'(4 * k)) ^ K);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    mem_const = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      decode_ready_i = ($urandom_range(0, 9) < 7);
      redirect_i     = ($urandom_range(0, 24) == 0);
      redirect_pc_i  = $urandom;
      if ($urandom_range(0, 7) == 0) mem_lat = $urandom_range(0, 3);
      @(negedge clk_i);
      n_checks++; if (clear_o !== redirect_i) $display("FAIL rnd_clear c=%0d got=%b exp=%b", c, clear_o, redirect_i); else n_pass++;
      n_checks++; if (data_ready_o !== e_valid) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, data_ready_o, e_valid); else n_pass++;
      if (e_valid) begin
        n_checks++;
        if ({instruction_o, pc_data_o} !== {m_ins[0], m_pc[0]})
          $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h", c, instruction_o, pc_data_o, m_ins[0], m_pc[0]);
        else n_pass++;
      end
      n_checks++; if (mem_req_o !== e_req) $display("FAIL rnd_req c=%0d got=%b exp=%b", c, mem_req_o, e_req); else n_pass++;
      if (e_req) begin
        n_checks++; if (mem_addr_o !== e_addr) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr_o, e_addr); else n_pass++;
      end
    end
    tick();
    redirect_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_pending();
    test_redirect_ack_pop($urandom | 32'h0000_2000, "rap");
    test_redirect_ack_pop(32'hFFFF_FFF8, "wrap");
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
